ex_mem_stage: RTL and testbench
===============================

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 Parameter: DATA_W, 32, datapath width of all data and address fields.
REQ-002 Parameter: REG_W, 5, register-specifier width.
REQ-003 Clk  in  1  sole clock; all state updates on rising edge.
REQ-004 Rst  in  1  asynchronous, active-high reset.
REQ-005 Stall  in  1  hold all stage contents.
REQ-006 Flush  in  1  replace the captured entry with a bubble.
REQ-007 InValid  in  1  EX-stage entry is a real instruction.
REQ-008 IsBranch  in  1  EX entry is a conditional branch.
REQ-009 BranchOp  in  6  branch selector: 100001 bgez, 000100 beq, 000101 bne, 000111 bgtz, 000110 blez, 011011 bltz.
REQ-010 A, B  in  DATA_W each  signed operands, the same values the ALU consumes.
REQ-011 ALUResult  in  DATA_W  ALU output.
REQ-012 WriteData  in  DATA_W  store data.
REQ-013 BranchTarget  in  DATA_W  precomputed target address.
REQ-014 WriteReg  in  REG_W; RegWrite, MemRead, MemWrite, MemToReg  in  1 each  control fields.
REQ-015 OutValid, OutRegWrite, OutMemRead, OutMemWrite, OutMemToReg  out  1 each  registered copies of the inputs.
REQ-016 OutALUResult, OutWriteData, OutBranchTarget  out  DATA_W; OutWriteReg  out  REG_W  registered copies.
REQ-017 BranchTaken  out  1  single-cycle pulse: the registered branch is taken.
REQ-018 FlushUp  out  1  equals BranchTaken; flushes IF/ID and ID/EX.

Function
REQ-019 Capture: on each edge with Stall=0, all Out* fields shall load their inputs with 1-cycle latency.
REQ-020 Stall=1 with Flush=0 shall hold every register unchanged.
REQ-021 Flush=1 shall load a bubble regardless of Stall: OutValid, OutRegWrite, OutMemRead, OutMemWrite and the taken flag are 0; data fields are don't-care but shall be driven to 0.
REQ-022 Squash: in the cycle after BranchTaken=1, the captured entry is the wrong-path instruction and shall be loaded as a bubble, identical to Flush.
REQ-023 Branch condition, evaluated combinationally on signed A/B: bgez A>=0; beq A==B; bne A!=B; bgtz A>0; blez A<=0; bltz A<0.
REQ-024 Any other BranchOp value, or IsBranch=0, or InValid=0, shall evaluate to not taken.
REQ-025 The taken flag shall be registered alongside the entry.
REQ-026 BranchTaken = taken flag AND OutValid AND NOT reported, where reported is set after the first pulse and cleared on every new capture.
REQ-027 As a result, a taken branch held by Stall shall pulse BranchTaken exactly once.
REQ-028 OutRegWrite shall be forced to 0 when the captured WriteReg is 0.
REQ-029 An entry with MemRead=1 and MemWrite=1 both set is illegal; the stage shall pass it through unchanged and take no corrective action.
REQ-030 Simultaneous Flush and squash shall produce a single bubble.

Reset
REQ-031 Rst=1 shall immediately clear all Out* registers, the taken flag and the reported flag to 0; BranchTaken and FlushUp shall be 0.
REQ-032 Rst asserted mid-stall shall override the hold.
REQ-033 The first edge after Rst deasserts shall capture normally, with no squash pending.

Structure
REQ-034 Package ex_mem_pkg shall hold the six BranchOp constants plus DATA_W and REG_W defaults.
REQ-035 Sub-module branch_compare shall be purely combinational: A, B, BranchOp, IsBranch, InValid -> taken.
REQ-036 All state shall reside in ex_mem_stage.

Verification
REQ-037 beq, A=5, B=5, InValid=1 -> next cycle BranchTaken=1 and OutBranchTarget=target; the following capture shall show OutValid=0.
REQ-038 bltz, A=0x80000000 -> taken; bgtz, A=0 -> not taken; blez, A=0 -> taken (signed edge cases).
REQ-039 Taken bne captured, then Stall=1 for 3 cycles -> BranchTaken high for exactly 1 cycle; outputs held.
REQ-040 Stall=1 and Flush=1 together -> bubble loaded; WriteReg=0 with RegWrite=1 -> OutRegWrite=0.
REQ-041 Rst pulsed mid-stall with a valid load held -> all outputs 0 immediately; the next capture proceeds without squash.
REQ-042 BranchOp=6'b111111 with IsBranch=1 -> never taken; the ALU result passes through unchanged.

Source files
------------

// File: rtl/ex_mem_pkg.sv
// Shared constants for the EX/MEM pipeline register: datapath defaults and
// the branch selector encodings decoded by branch_compare.
package ex_mem_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_REG_W  = 5;

    localparam logic [5:0] BOP_BGEZ = 6'b100001;
    localparam logic [5:0] BOP_BEQ  = 6'b000100;
    localparam logic [5:0] BOP_BNE  = 6'b000101;
    localparam logic [5:0] BOP_BGTZ = 6'b000111;
    localparam logic [5:0] BOP_BLEZ = 6'b000110;
    localparam logic [5:0] BOP_BLTZ = 6'b011011;

endpackage

// File: rtl/ex_mem_stage_branch_compare.sv
// Combinational branch resolution on the signed ALU operands; unknown
// selectors, non-branches and invalid entries resolve to not taken.
module branch_compare
    import ex_mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic [5:0]        BranchOp,
    input  logic              IsBranch,
    input  logic              InValid,
    output logic              taken
);

    logic a_neg_s;
    logic a_zero_s;
    logic cond_s;

    assign a_neg_s  = A[DATA_W-1];
    assign a_zero_s = (A == {DATA_W{1'b0}});

    // Condition decode; sign-bit tests are the signed compares against zero.
    always_comb begin
        cond_s = 1'b0;
        case (BranchOp)
            BOP_BGEZ: cond_s = ~a_neg_s;
            BOP_BEQ:  cond_s = (A == B);
            BOP_BNE:  cond_s = (A != B);
            BOP_BGTZ: cond_s = ~a_neg_s & ~a_zero_s;
            BOP_BLEZ: cond_s = a_neg_s | a_zero_s;
            BOP_BLTZ: cond_s = a_neg_s;
            default:  cond_s = 1'b0;
        endcase
    end

    assign taken = cond_s & IsBranch & InValid;

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with branch resolution, one-shot taken pulse and
// squash of the wrong-path entry that follows a taken branch.
module ex_mem_stage
    import ex_mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_W  = DEF_REG_W
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Stall,
    input  logic              Flush,
    input  logic              InValid,
    input  logic              IsBranch,
    input  logic [5:0]        BranchOp,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic [DATA_W-1:0] ALUResult,
    input  logic [DATA_W-1:0] WriteData,
    input  logic [DATA_W-1:0] BranchTarget,
    input  logic [REG_W-1:0]  WriteReg,
    input  logic              RegWrite,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              MemToReg,
    output logic              OutValid,
    output logic              OutRegWrite,
    output logic              OutMemRead,
    output logic              OutMemWrite,
    output logic              OutMemToReg,
    output logic [DATA_W-1:0] OutALUResult,
    output logic [DATA_W-1:0] OutWriteData,
    output logic [DATA_W-1:0] OutBranchTarget,
    output logic [REG_W-1:0]  OutWriteReg,
    output logic              BranchTaken,
    output logic              FlushUp
);

    logic              taken_s;
    logic              branch_taken_s;
    logic              bubble_s;

    logic              valid_r;
    logic              reg_write_r;
    logic              mem_read_r;
    logic              mem_write_r;
    logic              mem_to_reg_r;
    logic [DATA_W-1:0] alu_result_r;
    logic [DATA_W-1:0] write_data_r;
    logic [DATA_W-1:0] branch_target_r;
    logic [REG_W-1:0]  write_reg_r;
    logic              taken_r;
    logic              reported_r;

    branch_compare #(.DATA_W(DATA_W)) u_branch_compare (
        .A        (A),
        .B        (B),
        .BranchOp (BranchOp),
        .IsBranch (IsBranch),
        .InValid  (InValid),
        .taken    (taken_s)
    );

    // A squash only applies when the stage would capture; a stalled branch keeps its slot.
    assign branch_taken_s = taken_r & valid_r & ~reported_r;
    assign bubble_s       = Flush | (branch_taken_s & ~Stall);

    // Stage register: reset, bubble, capture, or hold while remembering the reported pulse.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            valid_r         <= 1'b0;
            reg_write_r     <= 1'b0;
            mem_read_r      <= 1'b0;
            mem_write_r     <= 1'b0;
            mem_to_reg_r    <= 1'b0;
            alu_result_r    <= {DATA_W{1'b0}};
            write_data_r    <= {DATA_W{1'b0}};
            branch_target_r <= {DATA_W{1'b0}};
            write_reg_r     <= {REG_W{1'b0}};
            taken_r         <= 1'b0;
            reported_r      <= 1'b0;
        end else if (bubble_s) begin
            valid_r         <= 1'b0;
            reg_write_r     <= 1'b0;
            mem_read_r      <= 1'b0;
            mem_write_r     <= 1'b0;
            mem_to_reg_r    <= 1'b0;
            alu_result_r    <= {DATA_W{1'b0}};
            write_data_r    <= {DATA_W{1'b0}};
            branch_target_r <= {DATA_W{1'b0}};
            write_reg_r     <= {REG_W{1'b0}};
            taken_r         <= 1'b0;
            reported_r      <= 1'b0;
        end else if (!Stall) begin
            valid_r         <= InValid;
            reg_write_r     <= RegWrite & (WriteReg != {REG_W{1'b0}});
            mem_read_r      <= MemRead;
            mem_write_r     <= MemWrite;
            mem_to_reg_r    <= MemToReg;
            alu_result_r    <= ALUResult;
            write_data_r    <= WriteData;
            branch_target_r <= BranchTarget;
            write_reg_r     <= WriteReg;
            taken_r         <= taken_s;
            reported_r      <= 1'b0;
        end else begin
            reported_r      <= reported_r | branch_taken_s;
        end
    end

    assign OutValid        = valid_r;
    assign OutRegWrite     = reg_write_r;
    assign OutMemRead      = mem_read_r;
    assign OutMemWrite     = mem_write_r;
    assign OutMemToReg     = mem_to_reg_r;
    assign OutALUResult    = alu_result_r;
    assign OutWriteData    = write_data_r;
    assign OutBranchTarget = branch_target_r;
    assign OutWriteReg     = write_reg_r;
    assign BranchTaken     = branch_taken_s;
    assign FlushUp         = branch_taken_s;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed self-checking bench for ex_mem_stage: one task per scenario with
// hand-computed expectations.
module tb_ex_mem_stage;

    logic        Clk, Rst, Stall, Flush, InValid, IsBranch;
    logic [5:0]  BranchOp;
    logic [31:0] A, B, ALUResult, WriteData, BranchTarget;
    logic [4:0]  WriteReg;
    logic        RegWrite, MemRead, MemWrite, MemToReg;
    logic        OutValid, OutRegWrite, OutMemRead, OutMemWrite, OutMemToReg;
    logic [31:0] OutALUResult, OutWriteData, OutBranchTarget;
    logic [4:0]  OutWriteReg;
    logic        BranchTaken, FlushUp;

    int passed = 0;
    int total  = 0;

    ex_mem_stage #(.DATA_W(32), .REG_W(5)) dut (
        .Clk(Clk), .Rst(Rst), .Stall(Stall), .Flush(Flush),
        .InValid(InValid), .IsBranch(IsBranch), .BranchOp(BranchOp),
        .A(A), .B(B), .ALUResult(ALUResult), .WriteData(WriteData),
        .BranchTarget(BranchTarget), .WriteReg(WriteReg), .RegWrite(RegWrite),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemToReg(MemToReg),
        .OutValid(OutValid), .OutRegWrite(OutRegWrite), .OutMemRead(OutMemRead),
        .OutMemWrite(OutMemWrite), .OutMemToReg(OutMemToReg),
        .OutALUResult(OutALUResult), .OutWriteData(OutWriteData),
        .OutBranchTarget(OutBranchTarget), .OutWriteReg(OutWriteReg),
        .BranchTaken(BranchTaken), .FlushUp(FlushUp)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_entry(input logic v, input logic br, input logic [5:0] op,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] alu, input logic [31:0] wd,
                             input logic [31:0] tgt, input logic [4:0] wr,
                             input logic rw, input logic mr, input logic mw,
                             input logic mtr);
        InValid = v; IsBranch = br; BranchOp = op; A = a; B = b;
        ALUResult = alu; WriteData = wd; BranchTarget = tgt; WriteReg = wr;
        RegWrite = rw; MemRead = mr; MemWrite = mw; MemToReg = mtr;
    endtask

    task automatic idle();
        set_entry(1'b0, 1'b0, 6'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0,
                  1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        Rst = 1'b1; Stall = 1'b0; Flush = 1'b0;
        set_entry(1'b1, 1'b0, 6'd0, 32'd0, 32'd0, 32'h1111, 32'h2222, 32'h3333,
                  5'd4, 1'b1, 1'b1, 1'b0, 1'b1);
        step(); step();
        total++;
        if ({OutValid, OutRegWrite, OutMemRead, OutMemWrite, OutMemToReg} !== 5'b0) begin
            $display("FAIL reset_ctrl: got %b want 00000",
                     {OutValid, OutRegWrite, OutMemRead, OutMemWrite, OutMemToReg});
        end else passed++;
        total++;
        if ({OutALUResult, OutWriteData, OutBranchTarget} !== 96'd0 || OutWriteReg !== 5'd0) begin
            $display("FAIL reset_data: got %h %h %h %h want zeros",
                     OutALUResult, OutWriteData, OutBranchTarget, OutWriteReg);
        end else passed++;
        total++;
        if (BranchTaken !== 1'b0 || FlushUp !== 1'b0) begin
            $display("FAIL reset_taken: got %b%b want 00", BranchTaken, FlushUp);
        end else passed++;
        Rst = 1'b0;
        idle();
        step();
    endtask

    task automatic test_capture();
        set_entry(1'b1, 1'b0, 6'd0, 32'd7, 32'd9, 32'hDEADBEEF, 32'h12345678,
                  32'h00000400, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0);
        step();
        total++;
        if ({OutValid, OutRegWrite, OutMemRead, OutMemWrite, OutMemToReg} !== 5'b11010) begin
            $display("FAIL capture_ctrl: got %b want 11010",
                     {OutValid, OutRegWrite, OutMemRead, OutMemWrite, OutMemToReg});
        end else passed++;
        total++;
        if (OutALUResult !== 32'hDEADBEEF || OutWriteData !== 32'h12345678 ||
            OutBranchTarget !== 32'h00000400 || OutWriteReg !== 5'd9) begin
            $display("FAIL capture_data: got %h %h %h %h want deadbeef 12345678 00000400 09",
                     OutALUResult, OutWriteData, OutBranchTarget, OutWriteReg);
        end else passed++;
        total++;
        if (BranchTaken !== 1'b0) begin
            $display("FAIL capture_taken: got %b want 0", BranchTaken);
        end else passed++;
        idle();
        step();
    endtask

    task automatic test_beq_squash();
        set_entry(1'b1, 1'b1, 6'b000100, 32'd5, 32'd5, 32'd0, 32'd0, 32'h00001000,
                  5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        total++;
        if (BranchTaken !== 1'b1 || FlushUp !== 1'b1 || OutBranchTarget !== 32'h00001000) begin
            $display("FAIL beq_taken: got bt=%b fu=%b tgt=%h want 1 1 00001000",
                     BranchTaken, FlushUp, OutBranchTarget);
        end else passed++;
        set_entry(1'b1, 1'b0, 6'd0, 32'd0, 32'd0, 32'h55, 32'h66, 32'h77, 5'd3,
                  1'b1, 1'b0, 1'b0, 1'b0);
        step();
        total++;
        if (OutValid !== 1'b0 || OutRegWrite !== 1'b0 || OutALUResult !== 32'd0 ||
            BranchTaken !== 1'b0) begin
            $display("FAIL beq_squash: got v=%b rw=%b alu=%h bt=%b want 0 0 0 0",
                     OutValid, OutRegWrite, OutALUResult, BranchTaken);
        end else passed++;
        step();
        total++;
        if (OutValid !== 1'b1 || OutALUResult !== 32'h55) begin
            $display("FAIL beq_after: got v=%b alu=%h want 1 00000055", OutValid, OutALUResult);
        end else passed++;
        idle();
        step();
    endtask

    task automatic test_signed_edges();
        logic [5:0]  ops  [4] = '{6'b011011, 6'b000111, 6'b000110, 6'b100001};
        logic [31:0] avals[4] = '{32'h80000000, 32'd0, 32'd0, 32'hFFFFFFFF};
        logic        exp  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            set_entry(1'b1, 1'b1, ops[i], avals[i], 32'd0, 32'd0, 32'd0, 32'h200,
                      5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            step();
            total++;
            if (BranchTaken !== exp[i]) begin
                $display("FAIL signed_edge[%0d]: op=%b a=%h got %b want %b",
                         i, ops[i], avals[i], BranchTaken, exp[i]);
            end else passed++;
            idle();
            step(); step();
        end
    endtask

    task automatic test_stall_once();
        int pulses = 0;
        set_entry(1'b1, 1'b1, 6'b000101, 32'd1, 32'd2, 32'h0000A5A5, 32'd0,
                  32'h00000800, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        if (BranchTaken === 1'b1) pulses++;
        Stall = 1'b1;
        idle();
        for (int i = 0; i < 3; i++) begin
            step();
            if (BranchTaken === 1'b1) pulses++;
        end
        total++;
        if (pulses != 1) begin
            $display("FAIL stall_pulse_count: got %0d want 1", pulses);
        end else passed++;
        total++;
        if (OutValid !== 1'b1 || OutALUResult !== 32'h0000A5A5 ||
            OutBranchTarget !== 32'h00000800) begin
            $display("FAIL stall_hold: got v=%b alu=%h tgt=%h want 1 0000a5a5 00000800",
                     OutValid, OutALUResult, OutBranchTarget);
        end else passed++;
        Stall = 1'b0;
        step();
    endtask

    task automatic test_flush_regzero();
        set_entry(1'b1, 1'b0, 6'd0, 32'd0, 32'd0, 32'h99, 32'h98, 32'h97, 5'd2,
                  1'b1, 1'b0, 1'b0, 1'b0);
        step();
        Stall = 1'b1; Flush = 1'b1;
        step();
        total++;
        if (OutValid !== 1'b0 || OutRegWrite !== 1'b0 || OutALUResult !== 32'd0 ||
            OutWriteReg !== 5'd0) begin
            $display("FAIL stall_flush_bubble: got v=%b rw=%b alu=%h wr=%h want 0 0 0 0",
                     OutValid, OutRegWrite, OutALUResult, OutWriteReg);
        end else passed++;
        Stall = 1'b0; Flush = 1'b0;
        set_entry(1'b1, 1'b0, 6'd0, 32'd0, 32'd0, 32'h44, 32'd0, 32'd0, 5'd0,
                  1'b1, 1'b0, 1'b0, 1'b0);
        step();
        total++;
        if (OutValid !== 1'b1 || OutRegWrite !== 1'b0) begin
            $display("FAIL reg0_write: got v=%b rw=%b want 1 0", OutValid, OutRegWrite);
        end else passed++;
        set_entry(1'b1, 1'b0, 6'd0, 32'd0, 32'd0, 32'h45, 32'hCAFE, 32'd0, 5'd1,
                  1'b0, 1'b1, 1'b1, 1'b0);
        step();
        total++;
        if (OutMemRead !== 1'b1 || OutMemWrite !== 1'b1 || OutWriteData !== 32'hCAFE ||
            OutRegWrite !== 1'b0) begin
            $display("FAIL illegal_passthru: got mr=%b mw=%b wd=%h rw=%b want 1 1 0000cafe 0",
                     OutMemRead, OutMemWrite, OutWriteData, OutRegWrite);
        end else passed++;
        idle();
        step();
    endtask

    task automatic test_reset_midstall();
        set_entry(1'b1, 1'b0, 6'd0, 32'd0, 32'd0, 32'h2000, 32'd0, 32'd0, 5'd7,
                  1'b1, 1'b1, 1'b0, 1'b1);
        step();
        Stall = 1'b1;
        step();
        Rst = 1'b1;
        #1;
        total++;
        if ({OutValid, OutRegWrite, OutMemRead, OutMemToReg} !== 4'b0 ||
            OutALUResult !== 32'd0 || OutWriteReg !== 5'd0) begin
            $display("FAIL rst_midstall: got ctrl=%b alu=%h wr=%h want 0 0 0",
                     {OutValid, OutRegWrite, OutMemRead, OutMemToReg}, OutALUResult, OutWriteReg);
        end else passed++;
        @(negedge Clk);
        Rst = 1'b0;
        // taken branch held in stall, then reset: no squash may survive
        Stall = 1'b0;
        set_entry(1'b1, 1'b1, 6'b000100, 32'd3, 32'd3, 32'd0, 32'd0, 32'h40, 5'd0,
                  1'b0, 1'b0, 1'b0, 1'b0);
        step();
        Stall = 1'b1;
        idle();
        Rst = 1'b1;
        #1;
        total++;
        if (BranchTaken !== 1'b0 || FlushUp !== 1'b0 || OutValid !== 1'b0) begin
            $display("FAIL rst_branch: got bt=%b fu=%b v=%b want 0 0 0",
                     BranchTaken, FlushUp, OutValid);
        end else passed++;
        @(negedge Clk);
        Rst = 1'b0; Stall = 1'b0;
        set_entry(1'b1, 1'b0, 6'd0, 32'd0, 32'd0, 32'h3000, 32'd0, 32'd0, 5'd8,
                  1'b1, 1'b0, 1'b0, 1'b0);
        step();
        total++;
        if (OutValid !== 1'b1 || OutALUResult !== 32'h3000 || OutRegWrite !== 1'b1) begin
            $display("FAIL rst_then_capture: got v=%b alu=%h rw=%b want 1 00003000 1",
                     OutValid, OutALUResult, OutRegWrite);
        end else passed++;
        idle();
        step();
    endtask

    task automatic test_not_taken_cases();
        set_entry(1'b1, 1'b1, 6'b111111, 32'd0, 32'd0, 32'hBEEF0001, 32'd0, 32'h500,
                  5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        total++;
        if (BranchTaken !== 1'b0 || OutALUResult !== 32'hBEEF0001 || OutValid !== 1'b1) begin
            $display("FAIL bad_op: got bt=%b alu=%h v=%b want 0 beef0001 1",
                     BranchTaken, OutALUResult, OutValid);
        end else passed++;
        set_entry(1'b0, 1'b1, 6'b000100, 32'd4, 32'd4, 32'd0, 32'd0, 32'd0, 5'd0,
                  1'b0, 1'b0, 1'b0, 1'b0);
        step();
        total++;
        if (BranchTaken !== 1'b0) begin
            $display("FAIL invalid_beq: got %b want 0", BranchTaken);
        end else passed++;
        set_entry(1'b1, 1'b0, 6'b000100, 32'd4, 32'd4, 32'h10, 32'd0, 32'd0, 5'd0,
                  1'b0, 1'b0, 1'b0, 1'b0);
        step();
        total++;
        if (BranchTaken !== 1'b0) begin
            $display("FAIL nonbranch_beq: got %b want 0", BranchTaken);
        end else passed++;
        idle();
        step();
    endtask

    task automatic test_back_to_back();
        set_entry(1'b1, 1'b0, 6'd0, 32'd0, 32'd0, 32'hAAAA0000, 32'd1, 32'd2, 5'd10,
                  1'b1, 1'b0, 1'b0, 1'b0);
        step();
        set_entry(1'b1, 1'b0, 6'd0, 32'd0, 32'd0, 32'h0000BBBB, 32'd3, 32'd4, 5'd11,
                  1'b0, 1'b1, 1'b0, 1'b1);
        total++;
        if (OutALUResult !== 32'hAAAA0000 || OutWriteReg !== 5'd10 || OutRegWrite !== 1'b1) begin
            $display("FAIL b2b_first: got alu=%h wr=%h rw=%b want aaaa0000 0a 1",
                     OutALUResult, OutWriteReg, OutRegWrite);
        end else passed++;
        step();
        total++;
        if (OutALUResult !== 32'h0000BBBB || OutWriteReg !== 5'd11 || OutRegWrite !== 1'b0 ||
            OutMemRead !== 1'b1 || OutMemToReg !== 1'b1) begin
            $display("FAIL b2b_second: got alu=%h wr=%h rw=%b mr=%b mtr=%b want 0000bbbb 0b 0 1 1",
                     OutALUResult, OutWriteReg, OutRegWrite, OutMemRead, OutMemToReg);
        end else passed++;
        idle();
        step();
    endtask

    initial begin
        test_reset();
        test_capture();
        test_beq_squash();
        test_signed_edges();
        test_stall_once();
        test_flush_regzero();
        test_reset_midstall();
        test_not_taken_cases();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
